// File: rtl/ram_share_arb_if.sv
// ram_share_arb_if
//   Bundles the requester command/response signals and the RAM control pins
//   used by ram_share_arb.
//   slave  : arbiter view (commands and RD in, Ready/Rsp/RAM controls out)
//   master : environment view (requesters plus RAM primitive)
//   Requester side : Req{0,1}_Valid/Ready/Wr/Addr/WData/Be, Rsp{0,1}_Valid,
//                    Rsp_RData, Busy
//   RAM side       : WA, RA, WD, WEN, WClk_En, RClk_En, RD
interface ram_share_arb_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int WEN_W  = 2
);
   logic              Req0_Valid;
   logic              Req0_Ready;
   logic              Req0_Wr;
   logic [ADDR_W-1:0] Req0_Addr;
   logic [DATA_W-1:0] Req0_WData;
   logic [WEN_W-1:0]  Req0_Be;
   logic              Req1_Valid;
   logic              Req1_Ready;
   logic              Req1_Wr;
   logic [ADDR_W-1:0] Req1_Addr;
   logic [DATA_W-1:0] Req1_WData;
   logic [WEN_W-1:0]  Req1_Be;
   logic              Rsp0_Valid;
   logic              Rsp1_Valid;
   logic [DATA_W-1:0] Rsp_RData;
   logic              Busy;
   logic [ADDR_W-1:0] WA;
   logic [ADDR_W-1:0] RA;
   logic [DATA_W-1:0] WD;
   logic [WEN_W-1:0]  WEN;
   logic              WClk_En;
   logic              RClk_En;
   logic [DATA_W-1:0] RD;

   modport slave (
      input  Req0_Valid, Req0_Wr, Req0_Addr, Req0_WData, Req0_Be,
      input  Req1_Valid, Req1_Wr, Req1_Addr, Req1_WData, Req1_Be,
      input  RD,
      output Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid, Rsp_RData, Busy,
      output WA, RA, WD, WEN, WClk_En, RClk_En
   );

   modport master (
      output Req0_Valid, Req0_Wr, Req0_Addr, Req0_WData, Req0_Be,
      output Req1_Valid, Req1_Wr, Req1_Addr, Req1_WData, Req1_Be,
      output RD,
      input  Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid, Rsp_RData, Busy,
      input  WA, RA, WD, WEN, WClk_En, RClk_En
   );
endinterface

// File: rtl/ram_share_arb.sv
// ram_share_arb
//   Two-requester access controller for a single dual-port block RAM whose
//   write and read clocks are both Clk. Write and read ports are arbitrated
//   independently with round-robin priority; read data is returned on the
//   shared Rsp_RData bus with a per-requester valid, in issue order.
//
//   Ports:
//     Clk   : sole clock (also the RAM WClk/RClk)
//     Rst   : synchronous, active-high reset
//     bus   : ram_share_arb_if.slave -- requester commands/responses, Busy,
//             and the RAM pins WA/RA/WD/WEN/WClk_En/RClk_En/RD
//
//   Parameters: ADDR_W, DATA_W, WEN_W (= DATA_W/8), RD_LAT (1 or 2 only).
//
//   Optional feature: define RAM_ARB_CLEAR_EN to zero the whole RAM after
//   every reset (Busy high, requesters held off for 2**ADDR_W cycles).
module ram_share_arb #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int WEN_W  = 2,
   parameter int RD_LAT = 1
) (
   input  logic           Clk,
   input  logic           Rst,
   ram_share_arb_if.slave bus
);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

`ifdef RAM_ARB_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
`else
   localparam state_t RST_STATE = RUN;
`endif

   state_t state_q, state_d;
`ifdef RAM_ARB_CLEAR_EN
   logic [ADDR_W-1:0] cnt_q, cnt_d;
`endif
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [RD_LAT-1:0] tag_v_q, tag_id_q;
   logic              tag_v_d, tag_id_d;

   logic              run, clr;
   logic              wc0, wc1, rc0, rc1;
   logic              wg0, wg1, rg0, rg1;
   logic [ADDR_W-1:0] wa_sel, ra_sel;
   logic [DATA_W-1:0] wd_sel;
   logic [WEN_W-1:0]  wen_sel;

   // State register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q  <= RST_STATE;
`ifdef RAM_ARB_CLEAR_EN
         cnt_q    <= '0;
`endif
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         tag_v_q  <= '0;
         tag_id_q <= '0;
      end else begin
         state_q  <= state_d;
`ifdef RAM_ARB_CLEAR_EN
         cnt_q    <= cnt_d;
`endif
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         tag_v_q[0]  <= tag_v_d;
         tag_id_q[0] <= tag_id_d;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
`ifdef RAM_ARB_CLEAR_EN
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) begin
            state_d = RUN;
         end
      end
`else
      state_d = RUN;
`endif
   end

   // Output / arbitration logic
   always_comb begin
      // Commands are never accepted in the reset cycle or while clearing.
      run = !Rst && (state_q == RUN);
      clr = !Rst && (state_q == CLEAR);

      wc0 = bus.Req0_Valid &  bus.Req0_Wr;
      wc1 = bus.Req1_Valid &  bus.Req1_Wr;
      rc0 = bus.Req0_Valid & !bus.Req0_Wr;
      rc1 = bus.Req1_Valid & !bus.Req1_Wr;

      // Pointer value selects the winner only when both compete.
      wg0 = run & wc0 & (!wc1 | !wr_ptr_q);
      wg1 = run & wc1 & (!wc0 |  wr_ptr_q);
      rg0 = run & rc0 & (!rc1 | !rd_ptr_q);
      rg1 = run & rc1 & (!rc0 |  rd_ptr_q);

      wa_sel  = '0;
      wd_sel  = '0;
      wen_sel = '0;
      ra_sel  = '0;
      bus.WClk_En = 1'b0;
      bus.RClk_En = 1'b0;

      if (clr) begin
         bus.WClk_En = 1'b1;
         wen_sel     = '1;
`ifdef RAM_ARB_CLEAR_EN
         wa_sel      = cnt_q;
`endif
      end else if (wg0 | wg1) begin
         bus.WClk_En = 1'b1;
         wa_sel  = wg1 ? bus.Req1_Addr  : bus.Req0_Addr;
         wd_sel  = wg1 ? bus.Req1_WData : bus.Req0_WData;
         wen_sel = wg1 ? bus.Req1_Be    : bus.Req0_Be;
      end

      if (rg0 | rg1) begin
         bus.RClk_En = 1'b1;
         ra_sel      = rg1 ? bus.Req1_Addr : bus.Req0_Addr;
      end

      bus.WA  = wa_sel;
      bus.WD  = wd_sel;
      bus.WEN = wen_sel;
      bus.RA  = ra_sel;

      bus.Req0_Ready = wg0 | rg0;
      bus.Req1_Ready = wg1 | rg1;

      wr_ptr_d = wr_ptr_q;
      if (wg0) wr_ptr_d = 1'b1;
      else if (wg1) wr_ptr_d = 1'b0;

      rd_ptr_d = rd_ptr_q;
      if (rg0) rd_ptr_d = 1'b1;
      else if (rg1) rd_ptr_d = 1'b0;

      tag_v_d  = rg0 | rg1;
      tag_id_d = rg1;

      // Responses are suppressed in the reset cycle so dropped reads never
      // surface.
      bus.Rsp0_Valid = !Rst & tag_v_q[RD_LAT-1] & !tag_id_q[RD_LAT-1];
      bus.Rsp1_Valid = !Rst & tag_v_q[RD_LAT-1] &  tag_id_q[RD_LAT-1];
      bus.Rsp_RData  = bus.RD;

`ifdef RAM_ARB_CLEAR_EN
      bus.Busy = Rst | (state_q == CLEAR);
`else
      bus.Busy = 1'b0;
`endif
   end

endmodule

// File: tb/tb_ram_share_arb.sv
module tb_ram_share_arb;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;
   localparam int WEN_W  = 2;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef RAM_ARB_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   typedef struct {
      int unsigned       due;
      bit                id;
      logic [DATA_W-1:0] data;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
   logic [ADDR_W-1:0] a0 = '0, a1 = '0;
   logic [DATA_W-1:0] d0 = '0, d1 = '0;
   logic [WEN_W-1:0]  b0 = '0, b1 = '0;

   int n_cmp = 0;
   int n_bad = 0;

   // Per-instance taps for directed checks (index = RD_LAT-1)
   logic m_rdy0 [2];
   logic m_rdy1 [2];
   logic m_rsp0 [2];
   logic m_rsp1 [2];
   logic m_busy [2];
   logic [DATA_W-1:0] m_rdata [2];

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] pat(int unsigned a);
      return DATA_W'(a * 37 + 16'h1357);
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int LAT = g + 1;

      ram_share_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEN_W(WEN_W)) bus ();

      ram_share_arb #(
         .ADDR_W(ADDR_W),
         .DATA_W(DATA_W),
         .WEN_W (WEN_W),
         .RD_LAT(LAT)
      ) dut (
         .Clk(clk),
         .Rst(rst),
         .bus(bus)
      );

      assign bus.Req0_Valid = v0;
      assign bus.Req0_Wr    = w0;
      assign bus.Req0_Addr  = a0;
      assign bus.Req0_WData = d0;
      assign bus.Req0_Be    = b0;
      assign bus.Req1_Valid = v1;
      assign bus.Req1_Wr    = w1;
      assign bus.Req1_Addr  = a1;
      assign bus.Req1_WData = d1;
      assign bus.Req1_Be    = b1;

      assign m_rdy0[g]  = bus.Req0_Ready;
      assign m_rdy1[g]  = bus.Req1_Ready;
      assign m_rsp0[g]  = bus.Rsp0_Valid;
      assign m_rsp1[g]  = bus.Rsp1_Valid;
      assign m_busy[g]  = bus.Busy;
      assign m_rdata[g] = bus.Rsp_RData;

      // RAM primitive stand-in: sync read, optional output register
      logic [DATA_W-1:0] ram [DEPTH];
      logic [DATA_W-1:0] rd1 = '0, rd2 = '0;
      initial for (int i = 0; i < DEPTH; i++) ram[i] = pat(i);
      always @(posedge clk) begin
         if (bus.WClk_En)
            for (int b = 0; b < WEN_W; b++)
               if (bus.WEN[b]) ram[bus.WA][b*8 +: 8] <= bus.WD[b*8 +: 8];
         if (bus.RClk_En) rd1 <= ram[bus.RA];
         rd2 <= rd1;
      end
      assign bus.RD = (LAT == 1) ? rd1 : rd2;

      // Reference model
      logic [DATA_W-1:0] rmem [DEPTH];
      rsp_t q[$];
      int unsigned wptr = 0, rptr = 0, ccnt = 0, mcyc = 0;
      bit clearing = 1'b0;
      initial for (int i = 0; i < DEPTH; i++) rmem[i] = pat(i);

      always @(negedge clk) begin : model
         logic er0, er1, ewe, ere, erdy0, erdy1, wid, rid, wgo, rgo;
         logic wc0, wc1, rc0, rc1;
         logic [DATA_W-1:0] erd, ewd;
         logic [ADDR_W-1:0] ewa, era;
         logic [WEN_W-1:0]  ewen;
         logic ebusy;
         rsp_t e;

         mcyc++;
         er0 = 0; er1 = 0; erd = '0;
         if (!rst && q.size() != 0 && q[0].due == mcyc) begin
            er0 = !q[0].id;
            er1 =  q[0].id;
            erd =  q[0].data;
            void'(q.pop_front());
         end
         chk($sformatf("L%0d rsp0_valid", LAT), 32'(bus.Rsp0_Valid), 32'(er0));
         chk($sformatf("L%0d rsp1_valid", LAT), 32'(bus.Rsp1_Valid), 32'(er1));
         if (er0 | er1) chk($sformatf("L%0d rsp_rdata", LAT), 32'(bus.Rsp_RData), 32'(erd));

         ewe = 0; ere = 0; erdy0 = 0; erdy1 = 0; ewa = '0; era = '0; ewd = '0;
         ewen = '0; ebusy = 0; wgo = 0; rgo = 0; wid = 0; rid = 0;
         if (rst) begin
            ebusy = CLR;
         end else if (clearing) begin
            ewe = 1; ewa = ADDR_W'(ccnt); ewen = '1; ebusy = 1;
         end else begin
            wc0 = v0 & w0;  wc1 = v1 & w1;
            rc0 = v0 & !w0; rc1 = v1 & !w1;
            if (wc0 && wc1) begin wgo = 1; wid = (wptr == 1); end
            else if (wc0 || wc1) begin wgo = 1; wid = wc1; end
            if (rc0 && rc1) begin rgo = 1; rid = (rptr == 1); end
            else if (rc0 || rc1) begin rgo = 1; rid = rc1; end
            if (wgo) begin
               ewe = 1;
               ewa = wid ? a1 : a0; ewd = wid ? d1 : d0; ewen = wid ? b1 : b0;
               if (wid) erdy1 = 1; else erdy0 = 1;
               wptr = wid ? 0 : 1;
            end
            if (rgo) begin
               ere = 1;
               era = rid ? a1 : a0;
               if (rid) erdy1 = 1; else erdy0 = 1;
               rptr = rid ? 0 : 1;
               e.due = mcyc + LAT; e.id = rid; e.data = rmem[era];
               q.push_back(e);
            end
         end

         chk($sformatf("L%0d req0_ready", LAT), 32'(bus.Req0_Ready), 32'(erdy0));
         chk($sformatf("L%0d req1_ready", LAT), 32'(bus.Req1_Ready), 32'(erdy1));
         chk($sformatf("L%0d wclk_en", LAT), 32'(bus.WClk_En), 32'(ewe));
         chk($sformatf("L%0d wa", LAT), 32'(bus.WA), 32'(ewa));
         chk($sformatf("L%0d wd", LAT), 32'(bus.WD), 32'(ewd));
         chk($sformatf("L%0d wen", LAT), 32'(bus.WEN), 32'(ewen));
         chk($sformatf("L%0d rclk_en", LAT), 32'(bus.RClk_En), 32'(ere));
         chk($sformatf("L%0d ra", LAT), 32'(bus.RA), 32'(era));
         chk($sformatf("L%0d busy", LAT), 32'(bus.Busy), 32'(ebusy));

         if (rst) begin
            wptr = 0; rptr = 0; q.delete(); clearing = CLR; ccnt = 0;
         end else if (clearing) begin
            rmem[ccnt] = '0;
            if (ccnt == DEPTH - 1) clearing = 0;
            ccnt++;
         end else if (wgo) begin
            for (int b = 0; b < WEN_W; b++)
               if (ewen[b]) rmem[ewa][b*8 +: 8] = ewd[b*8 +: 8];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(logic wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic [WEN_W-1:0] be);
      v0 = 1; w0 = wr; a0 = a; d0 = d; b0 = be;
   endtask

   task automatic set1(logic wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, logic [WEN_W-1:0] be);
      v1 = 1; w1 = wr; a1 = a; d1 = d; b1 = be;
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int busy_cnt;
      bit found;
      bit gid [16];
      logic [ADDR_W-1:0] fa0, fa1;
      logic r0, r1;

      rst = 1;
      repeat (3) step();
      rst = 0;

      // Clear sweep length (also Busy tied low without the clear feature)
      busy_cnt = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (!m_busy[0]) break;
         busy_cnt++;
         step();
      end
      chk("busy_cycles", 32'(busy_cnt), CLR ? 32'd1024 : 32'd0);
      step();

`ifdef RAM_ARB_CLEAR_EN
      set0(0, 10'h3FF, '0, '0);
      @(negedge clk); chk("clr_rd_ready", 32'(m_rdy0[0]), 1);
      step(); v0 = 0;
      @(negedge clk);
      chk("clr_rd_valid", 32'(m_rsp0[0]), 1);
      chk("clr_rd_data", 32'(m_rdata[0]), 32'h0000);
      step();
`endif

      // Write conflict
      set0(1, 10'h010, 16'hAAAA, 2'b11);
      set1(1, 10'h011, 16'h5555, 2'b11);
      @(negedge clk);
      chk("wc_t_rdy0", 32'(m_rdy0[0]), 1);
      chk("wc_t_rdy1", 32'(m_rdy1[0]), 0);
      step(); v0 = 0;
      @(negedge clk);
      chk("wc_t1_rdy1", 32'(m_rdy1[0]), 1);
      step(); v1 = 0;

      set0(0, 10'h010, '0, '0);
      step(); v0 = 0; set1(0, 10'h011, '0, '0);
      @(negedge clk);
      chk("wc_rd0_valid", 32'(m_rsp0[0]), 1);
      chk("wc_rd0_data", 32'(m_rdata[0]), 32'hAAAA);
      step(); v1 = 0;
      @(negedge clk);
      chk("wc_rd1_valid", 32'(m_rsp1[0]), 1);
      chk("wc_rd1_data", 32'(m_rdata[0]), 32'h5555);
      step();

      // Concurrent write and read of one address
      set0(1, 10'h020, 16'h1234, 2'b11);
      set1(0, 10'h020, '0, '0);
      @(negedge clk);
      chk("cc_rdy0", 32'(m_rdy0[0]), 1);
      chk("cc_rdy1", 32'(m_rdy1[0]), 1);
      step(); v0 = 0;
      @(negedge clk);
      chk("cc_old_valid", 32'(m_rsp1[0]), 1);
      chk("cc_old_data", 32'(m_rdata[0]), CLR ? 32'h0 : 32'(pat(32'h020)));
      step(); v1 = 0;
      @(negedge clk);
      chk("cc_new_valid", 32'(m_rsp1[0]), 1);
      chk("cc_new_data", 32'(m_rdata[0]), 32'h1234);
      step();

      // Byte enables
      set0(1, 10'h030, 16'hFFFF, 2'b11); step();
      set0(1, 10'h030, 16'h0000, 2'b01); step();
      set0(0, 10'h030, '0, '0); step();
      v0 = 0;
      @(negedge clk);
      chk("be_valid", 32'(m_rsp0[0]), 1);
      chk("be_data", 32'(m_rdata[0]), 32'hFF00);
      step();

      // Read fairness, observed on the RD_LAT=2 instance
      fa0 = 10'h100; fa1 = 10'h200;
      for (int k = 0; k < 12; k++) begin
         set0(0, fa0, '0, '0);
         set1(0, fa1, '0, '0);
         @(negedge clk);
         r0 = m_rdy0[1]; r1 = m_rdy1[1];
         chk("fair_one_grant", 32'(r0) + 32'(r1), 1);
         gid[k] = r1;
         if (k > 0) chk("fair_alternate", 32'(r1), 32'(!gid[k-1]));
         if (k >= 2) chk("fair_lat2", gid[k-2] ? 32'(m_rsp1[1]) : 32'(m_rsp0[1]), 1);
         if (r0) fa0++;
         if (r1) fa1++;
         step();
      end

      // Reset with two reads in flight; both requesters keep reading
      rst = 1;
      @(negedge clk);
      chk("rst_rdy0", 32'(m_rdy0[1]), 0);
      chk("rst_rdy1", 32'(m_rdy1[1]), 0);
      step(); rst = 0;
      found = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (i < 2) begin
            chk("rst_drop0", 32'(m_rsp0[1]), 0);
            chk("rst_drop1", 32'(m_rsp1[1]), 0);
         end
         if (!m_busy[1]) begin found = 1; break; end
         step();
      end
      chk("rst_run_reached", 32'(found), 1);
      chk("rst_next_rdy0", 32'(m_rdy0[1]), 1);
      chk("rst_next_rdy1", 32'(m_rdy1[1]), 0);
      step();

      // Randomized traffic on a small address window
      for (int c = 0; c < 3000; c++) begin
         v0 = ($urandom_range(0, 3) != 0); w0 = $urandom_range(0, 1);
         a0 = 10'h3F0 + ADDR_W'($urandom_range(0, 15));
         d0 = DATA_W'($urandom); b0 = WEN_W'($urandom);
         v1 = ($urandom_range(0, 3) != 0); w1 = $urandom_range(0, 1);
         a1 = 10'h3F0 + ADDR_W'($urandom_range(0, 15));
         d1 = DATA_W'($urandom); b1 = WEN_W'($urandom);
         rst = ($urandom_range(0, 699) == 0);
         step();
      end
      rst = 0; v0 = 0; v1 = 0;
      repeat (5) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ram_share_arb.md
# ram_share_arb

Two-requester access controller for one 1024x16 block RAM, one clock domain. It arbitrates the RAM write port and read port independently with round-robin priority, drives the RAM control pins (address, data, byte enables, port enables) and routes read data back to the owning requester. It sits between two datapath clients (e.g. DMA and CPU bridge) and a single RAM_16K_BLK-style primitive whose WClk and RClk are both tied to Clk.

## Interface

- ADDR_W, 10, address width (depth = 2**ADDR_W)
- DATA_W, 16, data width
- WEN_W, 2, byte-enable width (DATA_W/8)
- RD_LAT, 1, RAM read latency in cycles: 1 = unregistered RAM output, 2 = registered RAM output; only 1 and 2 are legal

Ports:

- Clk  in  1  sole clock; also drives RAM WClk and RClk
- Rst  in  1  synchronous, active-high reset
- Req0_Valid / Req1_Valid  in  1  command valid
- Req0_Ready / Req1_Ready  out  1  command accepted this cycle (combinational)
- Req0_Wr / Req1_Wr  in  1  1 = write, 0 = read
- Req0_Addr / Req1_Addr  in  ADDR_W  word address
- Req0_WData / Req1_WData  in  DATA_W  write data
- Req0_Be / Req1_Be  in  WEN_W  byte enables (bit i covers byte i)
- Rsp0_Valid / Rsp1_Valid  out  1  read data for that requester on Rsp_RData
- Rsp_RData  out  DATA_W  shared read-return bus, pass-through of RD
- Busy  out  1  clear sequence in progress
- WA, RA  out  ADDR_W  RAM write/read address
- WD  out  DATA_W  RAM write data
- WEN  out  WEN_W  RAM byte write enables, active high
- WClk_En, RClk_En  out  1  RAM port enables
- RD  in  DATA_W  RAM read data

## Operation

- FSM states CLEAR and RUN. With RAM_ARB_CLEAR_EN, Rst enters CLEAR; without it, Rst enters RUN.
- RUN: a command is accepted when Valid & Ready. Ready is combinational from Valid, Wr and the pointers. Requesters must not make Valid depend on Ready.
- Write arbitration: candidates are requesters with Valid & Wr.
  - Single candidate wins.
  - With two candidates, the winner is the one selected by wr_ptr.
  - After any grant, wr_ptr points to the other requester.
- Read arbitration: identical scheme using rd_ptr, with Valid & !Wr.
- One write and one read are granted in the same cycle when both exist, including from different requesters.
- Write grant: WClk_En=1, WA=Addr, WD=WData, WEN=Be. With no write grant: WClk_En=0, WEN=0, WA=0, WD=0.
- Read grant: RClk_En=1, RA=Addr. With no read grant: RClk_En=0, RA=0.
- The read tag {valid, id} enters an RD_LAT-deep shift register. At the output, Rsp{id}_Valid=1 for one cycle.
- Rsp_RData = RD at all times. It is meaningful only while a Rsp valid is high.
- A same-cycle write and read to the same address returns the old data; no forwarding.
- Responses always return in issue order.

## Timing

- Reset values:
  - Rsp0_Valid = Rsp1_Valid = 0
  - wr_ptr = rd_ptr = 0 (requester 0 has priority first)
  - Read tag pipeline cleared; in-flight reads are dropped
  - Busy = 1 if RAM_ARB_CLEAR_EN, else 0
  - RAM enables 0 during the reset cycle
- Read grant in cycle t: the RAM samples RA at the end of t, and Rsp valid is high in cycle t+RD_LAT.
- Write grant in cycle t: data is written at the end of t and is readable by a read granted in t+1.
- Throughput: one write plus one read per cycle.
- Rst asserted mid-operation: the command in that cycle is not accepted; the state is as listed under reset values.

## Configuration

- RAM_ARB_CLEAR_EN defined: after Rst, the block stays in CLEAR for 2**ADDR_W cycles.
  - Each cycle drives WClk_En=1, WEN=all ones, WD=0, WA=cnt, with cnt counting 0 to 2**ADDR_W-1.
  - Both Ready outputs are 0, RClk_En=0 and Busy=1.
  - In the cycle after cnt = 2**ADDR_W-1 is written, the FSM enters RUN and Busy drops to 0.
  - Rst during CLEAR restarts the sequence at cnt=0.
- RAM_ARB_CLEAR_EN not defined: there is no CLEAR state, Busy is tied to 0 and RAM contents after Rst are unchanged.

## Test plan

- Clear sequence (macro on): release Rst. Required: Busy=1 for exactly 1024 cycles, WA sweeps 0..1023 with WD=0 and WEN=2'b11, Ready stays 0. Then a read of address 0x3FF returns 0x0000.
- Write conflict: both requesters issue writes, Req0 to 0x010 with 0xAAAA and Req1 to 0x011 with 0x5555, held valid.
  - Required: Req0 is granted in cycle t and Req1 in t+1.
  - Required: subsequent reads return 0xAAAA and 0x5555 with the correct Rsp valid.
- Concurrent write and read, with RD_LAT=1:
  - Req0 writes 0x1234 to 0x020 in the same cycle t that Req1 reads 0x020.
  - Required: both Ready=1, Rsp1_Valid=1 at t+1 with the old data.
  - Required: a Req1 read of 0x020 granted at t+1 returns 0x1234 at t+2.
- Byte enables: write 0xFFFF to 0x030, then write 0x0000 with Be=2'b01. Required: a read returns 0xFF00.
- Read fairness with RD_LAT=2: both requesters stream reads continuously. Required: grants alternate 0,1,0,1, each Rsp valid arrives exactly 2 cycles after its grant, and data matches the address.
- Reset mid-stream: assert Rst for one cycle while two reads are in flight. Required: no Rsp valid appears afterwards for those reads, and the next grant goes to Req0.
